// File: rtl/ibex_csr_bank.sv
// ibex_csr_bank: small bank of NumRegs x Width control registers with
// write/set/clear operations, sticky per-register write lock, an optional
// inverted shadow copy per register, and a background scrubber that walks
// the bank and records the first register whose shadow disagrees.
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   addr_i             register select for read, write and lock
//   wr_en_i/wr_op_i    write request; op 00 write, 01 set, 10 clear, 11 reserved
//   wr_data_i          write operand
//   lock_i             lock the addressed register (until reset)
//   err_clr_i          clear the sticky scrub error
//   rd_data_o          addressed register (0 when addr out of range)
//   rd_error_o         addressed register fails its shadow check
//   wr_err_o           pulse, cycle after a rejected write
//   locked_o           per-register lock state
//   scrub_err_o        sticky background-check failure
//   scrub_idx_o        index of the first failing register
module ibex_csr_bank #(
    parameter int               Width      = 32,
    parameter int               NumRegs    = 4,
    parameter bit               ShadowCopy = 1'b1,
    parameter logic [Width-1:0] ResetValue = '0,
    localparam int              AddrW      = $clog2(NumRegs)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [AddrW-1:0]   addr_i,
    input  logic               wr_en_i,
    input  logic [1:0]         wr_op_i,
    input  logic [Width-1:0]   wr_data_i,
    input  logic               lock_i,
    input  logic               err_clr_i,
    output logic [Width-1:0]   rd_data_o,
    output logic               rd_error_o,
    output logic               wr_err_o,
    output logic [NumRegs-1:0] locked_o,
    output logic               scrub_err_o,
    output logic [AddrW-1:0]   scrub_idx_o
);

    logic [NumRegs-1:0][Width-1:0] reg_q;
    logic [NumRegs-1:0][Width-1:0] shadow_q;
    logic [NumRegs-1:0]            locked_q;
    logic                          wr_err_q;

    logic             in_range;
    logic [Width-1:0] cur_val;
    logic [Width-1:0] cur_shadow;
    logic             cur_locked;
    logic [Width-1:0] wr_next;
    logic             wr_ok;

    // Address decode done as a loop compare so non-power-of-two banks
    // reject the unused encodings without indexing past the array.
    always_comb begin
        in_range   = 1'b0;
        cur_val    = '0;
        cur_shadow = '0;
        cur_locked = 1'b0;
        for (int i = 0; i < NumRegs; i++) begin
            if (addr_i == AddrW'(i)) begin
                in_range   = 1'b1;
                cur_val    = reg_q[i];
                cur_shadow = shadow_q[i];
                cur_locked = locked_q[i];
            end
        end
    end

    always_comb begin
        wr_next = cur_val;
        unique case (wr_op_i)
            2'b00:   wr_next = wr_data_i;
            2'b01:   wr_next = cur_val | wr_data_i;
            2'b10:   wr_next = cur_val & ~wr_data_i;
            default: wr_next = cur_val;
        endcase
    end

    assign wr_ok = wr_en_i && in_range && !cur_locked && (wr_op_i != 2'b11);

    // Lock is evaluated against the pre-edge lock state, so a write in the
    // same cycle as the lock request still commits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_q    <= {NumRegs{ResetValue}};
            locked_q <= '0;
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_en_i && !wr_ok;
            for (int i = 0; i < NumRegs; i++) begin
                if (addr_i == AddrW'(i)) begin
                    if (wr_ok)  reg_q[i]    <= wr_next;
                    if (lock_i) locked_q[i] <= 1'b1;
                end
            end
        end
    end

    assign rd_data_o = cur_val;
    assign wr_err_o  = wr_err_q;
    assign locked_o  = locked_q;

    generate
        if (ShadowCopy) begin : g_shadow
            logic [AddrW-1:0] cnt_q;
            logic             mismatch;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    shadow_q <= {NumRegs{~ResetValue}};
                end else begin
                    for (int i = 0; i < NumRegs; i++) begin
                        if (wr_ok && addr_i == AddrW'(i)) shadow_q[i] <= ~wr_next;
                    end
                end
            end

            assign rd_error_o = in_range && (cur_val != ~cur_shadow);
            assign mismatch   = reg_q[cnt_q] != ~shadow_q[cnt_q];

            // A fresh mismatch outranks err_clr_i so a persistent fault is
            // never lost; the index then tracks the newly found register.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_q       <= '0;
                    scrub_err_o <= 1'b0;
                    scrub_idx_o <= '0;
                end else begin
                    cnt_q <= (cnt_q == AddrW'(NumRegs - 1)) ? '0 : cnt_q + AddrW'(1);
                    if (mismatch && (!scrub_err_o || err_clr_i)) begin
                        scrub_err_o <= 1'b1;
                        scrub_idx_o <= cnt_q;
                    end else if (err_clr_i) begin
                        scrub_err_o <= 1'b0;
                    end
                end
            end
        end else begin : g_no_shadow
            assign shadow_q    = '0;
            assign rd_error_o  = 1'b0;
            assign scrub_err_o = 1'b0;
            assign scrub_idx_o = '0;
        end
    endgenerate

endmodule

// File: doc/ibex_csr_bank.md
IBEX_CSR_BANK -- requirements
Module: ibex_csr_bank

Interface
REQ-001 SHALL have parameter Width, default 32, meaning bit width of each register.
REQ-002 SHALL have parameter NumRegs, default 4, meaning register count, legal range 2..16.
REQ-003 SHALL have parameter ShadowCopy, default 1'b1, meaning an inverted shadow copy is kept per register.
REQ-004 SHALL have parameter ResetValue [Width-1:0], default '0, meaning reset value of every register.
REQ-005 SHALL derive localparam AddrW = $clog2(NumRegs).
REQ-006 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-007 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port addr_i, input, AddrW, register select for read, write and lock.
REQ-009 SHALL have port wr_en_i, input, 1, write request this cycle.
REQ-010 SHALL have port wr_op_i, input, 2, operation: 00 write, 01 set, 10 clear, 11 reserved.
REQ-011 SHALL have port wr_data_i, input, Width, write operand.
REQ-012 SHALL have port lock_i, input, 1, lock the addressed register.
REQ-013 SHALL have port err_clr_i, input, 1, clear the sticky scrub error.
REQ-014 SHALL have port rd_data_o, output, Width, addressed register value.
REQ-015 SHALL have port rd_error_o, output, 1, addressed register fails its shadow check.
REQ-016 SHALL have port wr_err_o, output, 1, one-cycle pulse flagging a rejected write.
REQ-017 SHALL have port locked_o, output, NumRegs, per-register lock state.
REQ-018 SHALL have port scrub_err_o, output, 1, sticky background-check failure.
REQ-019 SHALL have port scrub_idx_o, output, AddrW, index of the first failing register.

Function
REQ-020 SHALL drive rd_data_o and rd_error_o combinationally from addr_i; out-of-range addr -> rd_data_o=0, rd_error_o=0.
REQ-021 SHALL commit an accepted write on the rising edge: op 00 -> reg=wr_data_i; 01 -> reg|=wr_data_i; 10 -> reg&=~wr_data_i; new value visible the next cycle.
REQ-022 SHALL update shadow to the bitwise inverse of the new register value in the same edge when ShadowCopy=1.
REQ-023 SHALL reject a write when the addressed register is locked, addr_i>=NumRegs, or wr_op_i=11; rejection leaves register and shadow unchanged.
REQ-024 SHALL assert wr_err_o for exactly the cycle after each rejected write; it stays 0 otherwise.
REQ-025 SHALL set locked_o[addr_i] on an edge with lock_i=1 and addr_i<NumRegs; lock is cleared only by reset.
REQ-026 SHALL, when lock_i and an accepted write coincide, commit the write first and then lock the register.
REQ-027 SHALL compute rd_error_o = (reg[addr_i] != ~shadow[addr_i]) when ShadowCopy=1, else 0.
REQ-028 SHALL run a scrub counter 0..NumRegs-1, advancing every cycle and wrapping from NumRegs-1 to 0.
REQ-029 SHALL, each cycle, compare reg[cnt] with ~shadow[cnt] using pre-edge values; on mismatch with scrub_err_o=0, set scrub_err_o and load scrub_idx_o=cnt on the next edge.
REQ-030 SHALL hold scrub_idx_o unchanged while scrub_err_o=1, recording the first error only.
REQ-031 SHALL clear scrub_err_o on an edge with err_clr_i=1; simultaneous clear and new mismatch -> scrub_err_o stays 1 and scrub_idx_o loads the new cnt.
REQ-032 SHALL, when ShadowCopy=0, omit shadow storage and tie scrub_err_o=0 and scrub_idx_o=0.

Reset
REQ-033 SHALL, while rst_i=1 and independent of clk_i, set every register to ResetValue, every shadow to ~ResetValue, locked_o=0, scrub counter=0, scrub_err_o=0, scrub_idx_o=0, wr_err_o=0.
REQ-034 SHALL discard any write or lock whose edge coincides with asserted rst_i; reset wins.

Verification
REQ-035 Reset then addr=2, write op 00 data 0x0000_00F0; next cycle op 01 data 0x0F; next op 10 data 0x30 -> rd_data_o 0xF0, 0xFF, 0xCF; rd_error_o=0 throughout.
REQ-036 addr=1, lock_i=1 with write 0xA5A5_A5A5 same cycle; then write 0x1234 -> reg1=0xA5A5_A5A5, locked_o=4'b0010, wr_err_o high one cycle after second write only.
REQ-037 Write with wr_op_i=11 to addr 0 -> reg0 unchanged, wr_err_o one-cycle pulse.
REQ-038 Force shadow[3] bit 0 flipped -> rd_error_o=1 when addr=3; within NumRegs+1 cycles scrub_err_o=1, scrub_idx_o=3; corrupt shadow[1] too -> scrub_idx_o stays 3.
REQ-039 With scrub_err_o=1 and mismatch still present, pulse err_clr_i -> scrub_err_o remains 1; remove fault, pulse err_clr_i -> scrub_err_o=0.
REQ-040 Assert rst_i asynchronously mid-write with locks set -> all regs=ResetValue, locked_o=0, scrub_err_o=0 immediately, before the next clk_i edge.
